datapath: RTL and testbench
===========================

// Module: datapath
// PURPOSE
//  16-bit single-bus CPU datapath: PC, IR, MAR, MDR, ALU input latches X/Y, ALU-result latch T,
//  flags, and an internal 8x16 register bank (submodule reg_bank). A separate control unit
//  drives every load/transfer strobe; memory is reached through abus (from MAR), datain and dataout.
// PARAMETERS
//  (none; width fixed at 16 bits, bank fixed at 8 registers)
// PORTS
//  clk      in   1   clock; all state updates on rising edge
//  rst      in   1   reset: one clock; reset is synchronous and active-high
//  lmar,lt,lpc,lir,lmdr,ldx,ldy  in 1 each   load strobes for MAR,T,PC,IR,MDR,X,Y
//  abus     out  16  memory address = MAR
//  tt,tpc,tp,t2  in 1 each   bus drivers: T, PC, bank read port, constant 0x0002
//  tmdr2x   in   1   X source = MDR (else bus)
//  tmdrext  in   1   bus driver: sign-extended IR[7:0]
//  rmdri    in   1   MDR source = datain (else bus)
//  rmarx    in   1   MAR source = X (else bus)
//  pa       in   3   bank read address
//  rdr      in   1   bank read enable (0 -> read port = 0)
//  wpa      in   3   bank write address
//  wrr      in   1   bank write enable (data = bus)
//  fnsel    in   3   ALU function
//  vin,cin,zin,sin out 1 each   overflow, carry/borrow, zero, sign flags
//  datain   in   16  memory read data
//  dataout  out  16  memory write data = MDR
// BEHAVIOUR
//  - Bus combinational; priority tt > tpc > tp > t2 > tmdrext; no driver -> 0x0000.
//  - tp drives R[pa] when rdr=1, else 0x0000. Bank read combinational.
//  - Bank write at edge when wrr=1: R[wpa] <= bus. Same-cycle read of R[wpa] returns old value.
//  - On edge: lmar: MAR <= rmarx ? X : bus. lpc: PC <= bus. lir: IR <= MDR.
//    lmdr: MDR <= rmdri ? datain : bus. ldx: X <= tmdr2x ? MDR : bus. ldy: Y <= bus.
//    lt: T <= Z (ALU out); flags updated only on lt.
//  - Strobes independent; any set may fire in one cycle, all sample pre-edge values.
//  - ALU Z=f(X,Y) combinational, 16-bit, wraps mod 2^16:
//    000 X+Y; 001 X-Y; 010 X&Y; 011 X|Y; 100 X^Y; 101 ~X; 110 X<<1; 111 X (pass).
//  - Flags from Z: zin=(Z==0), sin=Z[15].
//    ADD: cin=carry out, vin=signed overflow. SUB: cin=borrow (X<Y unsigned), vin=signed overflow.
//    SHL: cin=X[15], vin=0. Logic/pass: cin=0, vin=0.
//  - Reset (rst=1 at edge): PC,IR,MAR,MDR,X,Y,T,R0..R7,all flags <= 0. rst overrides all
//    strobes that cycle, including wrr. Outputs then abus=0, dataout=0, flags=0.
//  - Reset mid-operation: no pending state; next cycle starts from all-zero.
//  - reg_bank submodule ports: clk,rst,PA(3),rdr,wrr,wPA(16 data),out(16);
//    a separate write-address input carries wpa.
// TESTING
//  - rst 1 cycle -> abus=0, dataout=0, vin=cin=zin=sin=0, R[pa]=0 for all pa.
//  - datain=0x000C,rmdri+lmdr; tmdr2x+ldx; t2+ldy; fnsel=000,lt; tt -> bus=0x000E, flags all 0.
//  - X=0x0002,Y=0x0002,fnsel=001,lt -> T=0x0000, zin=1, cin=0; X=0x0001,Y=0x0002 -> T=0xFFFF, cin=1, sin=1.
//  - X=0x7FFF,Y=0x0001,fnsel=000,lt -> T=0x8000, vin=1, sin=1, cin=0.
//  - bus=0x0404,wrr,wpa=1; then bus=0x0407,wrr,wpa=2; tp,rdr,pa=1 -> bus=0x0404; pa=2 -> 0x0407; rdr=0 -> 0.
//  - IR=0x0080 (via MDR,lir), tmdrext -> bus=0xFF80; X=0x1234,rmarx+lmar -> abus=0x1234.

Source files
------------

// File: rtl/datapath.sv
// rtl/datapath.sv - 16-bit single-bus CPU datapath with PC/IR/MAR/MDR/X/Y/T, flags and 8x16 register bank
// All state updates on the rising edge; bus and ALU are combinational.

module reg_bank (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  PA,
  input  logic        rdr,
  input  logic        wrr,
  input  logic [2:0]  waddr,
  input  logic [15:0] wPA,
  output logic [15:0] out
);

  logic [15:0] regs_q [8];

  // Reads see the pre-edge contents, so a same-cycle write is not forwarded.
  assign out = rdr ? regs_q[PA] : 16'h0000;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) regs_q[i] <= 16'h0000;
    end else if (wrr) begin
      regs_q[waddr] <= wPA;
    end
  end

endmodule

module datapath (
  input  logic        clk,
  input  logic        rst,
  input  logic        lmar,
  input  logic        lt,
  input  logic        lpc,
  input  logic        lir,
  input  logic        lmdr,
  input  logic        ldx,
  input  logic        ldy,
  output logic [15:0] abus,
  input  logic        tt,
  input  logic        tpc,
  input  logic        tp,
  input  logic        t2,
  input  logic        tmdr2x,
  input  logic        tmdrext,
  input  logic        rmdri,
  input  logic        rmarx,
  input  logic [2:0]  pa,
  input  logic        rdr,
  input  logic [2:0]  wpa,
  input  logic        wrr,
  input  logic [2:0]  fnsel,
  output logic        vin,
  output logic        cin,
  output logic        zin,
  output logic        sin,
  input  logic [15:0] datain,
  output logic [15:0] dataout
);

  logic [15:0] pc_q, ir_q, mar_q, mdr_q, x_q, y_q, t_q;
  logic [15:0] pc_d, ir_d, mar_d, mdr_d, x_d, y_d, t_d;
  logic        v_q, c_q, z_q, s_q;
  logic        v_d, c_d, z_d, s_d;

  logic [15:0] bus;
  logic [15:0] bank_out;
  logic [15:0] alu_z;
  logic        alu_v, alu_c;
  logic [16:0] sum17, diff17;
  logic [7:0]  unused_ir_hi;

  assign unused_ir_hi = ir_q[15:8];

  reg_bank u_bank (
    .clk   (clk),
    .rst   (rst),
    .PA    (pa),
    .rdr   (rdr),
    .wrr   (wrr),
    .waddr (wpa),
    .wPA   (bus),
    .out   (bank_out)
  );

  always_comb begin
    if (tt)           bus = t_q;
    else if (tpc)     bus = pc_q;
    else if (tp)      bus = bank_out;
    else if (t2)      bus = 16'h0002;
    else if (tmdrext) bus = {{8{ir_q[7]}}, ir_q[7:0]};
    else              bus = 16'h0000;
  end

  assign sum17  = {1'b0, x_q} + {1'b0, y_q};
  assign diff17 = {1'b0, x_q} - {1'b0, y_q};

  // diff17[16] is set exactly when X < Y unsigned, i.e. the borrow.
  always_comb begin
    alu_z = 16'h0000;
    alu_v = 1'b0;
    alu_c = 1'b0;
    case (fnsel)
      3'b000: begin
        alu_z = sum17[15:0];
        alu_c = sum17[16];
        alu_v = (x_q[15] == y_q[15]) && (sum17[15] != x_q[15]);
      end
      3'b001: begin
        alu_z = diff17[15:0];
        alu_c = diff17[16];
        alu_v = (x_q[15] != y_q[15]) && (diff17[15] != x_q[15]);
      end
      3'b010: alu_z = x_q & y_q;
      3'b011: alu_z = x_q | y_q;
      3'b100: alu_z = x_q ^ y_q;
      3'b101: alu_z = ~x_q;
      3'b110: begin
        alu_z = {x_q[14:0], 1'b0};
        alu_c = x_q[15];
      end
      default: alu_z = x_q;
    endcase
  end

  always_comb begin
    pc_d  = lpc  ? bus : pc_q;
    ir_d  = lir  ? mdr_q : ir_q;
    mar_d = lmar ? (rmarx ? x_q : bus) : mar_q;
    mdr_d = lmdr ? (rmdri ? datain : bus) : mdr_q;
    x_d   = ldx  ? (tmdr2x ? mdr_q : bus) : x_q;
    y_d   = ldy  ? bus : y_q;
    t_d   = lt   ? alu_z : t_q;
    v_d   = lt   ? alu_v : v_q;
    c_d   = lt   ? alu_c : c_q;
    z_d   = lt   ? (alu_z == 16'h0000) : z_q;
    s_d   = lt   ? alu_z[15] : s_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q  <= 16'h0000;
      ir_q  <= 16'h0000;
      mar_q <= 16'h0000;
      mdr_q <= 16'h0000;
      x_q   <= 16'h0000;
      y_q   <= 16'h0000;
      t_q   <= 16'h0000;
      v_q   <= 1'b0;
      c_q   <= 1'b0;
      z_q   <= 1'b0;
      s_q   <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ir_q  <= ir_d;
      mar_q <= mar_d;
      mdr_q <= mdr_d;
      x_q   <= x_d;
      y_q   <= y_d;
      t_q   <= t_d;
      v_q   <= v_d;
      c_q   <= c_d;
      z_q   <= z_d;
      s_q   <= s_d;
    end
  end

  assign abus    = mar_q;
  assign dataout = mdr_q;
  assign vin     = v_q;
  assign cin     = c_q;
  assign zin     = z_q;
  assign sin     = s_q;

endmodule

// File: tb/tb_datapath.sv
// tb/tb_datapath.sv - randomized and directed self-checking bench for datapath
// A reference model tracks architectural state; outputs are compared every negedge.

module tb_datapath;

  logic        clk = 1'b0;
  logic        rst;
  logic        lmar, lt, lpc, lir, lmdr, ldx, ldy;
  logic        tt, tpc, tp, t2, tmdr2x, tmdrext, rmdri, rmarx;
  logic [2:0]  pa, wpa, fnsel;
  logic        rdr, wrr;
  logic [15:0] datain;
  logic [15:0] abus, dataout;
  logic        vin, cin, zin, sin;

  int checks = 0;
  int errors = 0;
  bit started = 0;

  logic [15:0] m_pc, m_ir, m_mar, m_mdr, m_x, m_y, m_t;
  logic [15:0] m_r [8];
  logic        m_v, m_c, m_z, m_s;

  datapath dut (
    .clk(clk), .rst(rst),
    .lmar(lmar), .lt(lt), .lpc(lpc), .lir(lir), .lmdr(lmdr), .ldx(ldx), .ldy(ldy),
    .abus(abus),
    .tt(tt), .tpc(tpc), .tp(tp), .t2(t2), .tmdr2x(tmdr2x), .tmdrext(tmdrext),
    .rmdri(rmdri), .rmarx(rmarx),
    .pa(pa), .rdr(rdr), .wpa(wpa), .wrr(wrr), .fnsel(fnsel),
    .vin(vin), .cin(cin), .zin(zin), .sin(sin),
    .datain(datain), .dataout(dataout)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic alu_model(input logic [2:0] f, input logic [15:0] a, input logic [15:0] b,
                           output logic [15:0] r, output logic v, output logic c);
    int u, si;
    v = 1'b0;
    c = 1'b0;
    case (f)
      3'd0: begin
        u  = int'(a) + int'(b);
        si = int'($signed(a)) + int'($signed(b));
        r  = u[15:0];
        c  = (u > 65535);
        v  = (si > 32767) || (si < -32768);
      end
      3'd1: begin
        u  = int'(a) - int'(b);
        si = int'($signed(a)) - int'($signed(b));
        r  = u[15:0];
        c  = (a < b);
        v  = (si > 32767) || (si < -32768);
      end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = 16'hFFFF - a;
      3'd6: begin
        u = int'(a) * 2;
        r = u[15:0];
        c = (a >= 16'h8000);
      end
      default: r = a;
    endcase
  endtask

  always @(negedge clk) begin
    if (started) begin
      checks++;
      if (abus !== m_mar || dataout !== m_mdr ||
          {vin, cin, zin, sin} !== {m_v, m_c, m_z, m_s}) begin
        errors++;
        $display("FAIL cycle_compare: got abus=%h dataout=%h vczs=%b, expected abus=%h dataout=%h vczs=%b",
                 abus, dataout, {vin, cin, zin, sin}, m_mar, m_mdr, {m_v, m_c, m_z, m_s});
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic idle();
    rst = 0; lmar = 0; lt = 0; lpc = 0; lir = 0; lmdr = 0; ldx = 0; ldy = 0;
    tt = 0; tpc = 0; tp = 0; t2 = 0; tmdr2x = 0; tmdrext = 0; rmdri = 0; rmarx = 0;
    pa = 0; rdr = 0; wpa = 0; wrr = 0; fnsel = 0; datain = 0;
  endtask

  // Advance one clock and move the model to its post-edge state.
  task automatic step();
    logic [15:0] b, rd, z, om, ox;
    logic v, c;
    rd = rdr ? m_r[pa] : 16'h0000;
    if (tt)           b = m_t;
    else if (tpc)     b = m_pc;
    else if (tp)      b = rd;
    else if (t2)      b = 16'h0002;
    else if (tmdrext) b = {{8{m_ir[7]}}, m_ir[7:0]};
    else              b = 16'h0000;
    alu_model(fnsel, m_x, m_y, z, v, c);
    om = m_mdr;
    ox = m_x;
    @(posedge clk);
    if (rst) begin
      m_pc = 0; m_ir = 0; m_mar = 0; m_mdr = 0; m_x = 0; m_y = 0; m_t = 0;
      for (int i = 0; i < 8; i++) m_r[i] = 0;
      m_v = 0; m_c = 0; m_z = 0; m_s = 0;
    end else begin
      if (wrr)  m_r[wpa] = b;
      if (lmar) m_mar = rmarx ? ox : b;
      if (lpc)  m_pc = b;
      if (lir)  m_ir = om;
      if (lmdr) m_mdr = rmdri ? datain : b;
      if (ldx)  m_x = tmdr2x ? om : b;
      if (ldy)  m_y = b;
      if (lt) begin
        m_t = z; m_v = v; m_c = c; m_z = (z == 16'h0000); m_s = z[15];
      end
    end
    #1;
  endtask

  task automatic load_mdr(input logic [15:0] d);
    idle(); datain = d; rmdri = 1; lmdr = 1; step();
  endtask

  task automatic load_x_from(input logic [15:0] d);
    load_mdr(d);
    idle(); tmdr2x = 1; ldx = 1; step();
  endtask

  task automatic t_to_mar();
    idle(); tt = 1; lmar = 1; step();
  endtask

  initial begin
    idle();
    m_pc = 'x; m_ir = 'x; m_mar = 'x; m_mdr = 'x; m_x = 'x; m_y = 'x; m_t = 'x;
    m_v = 'x; m_c = 'x; m_z = 'x; m_s = 'x;
    rst = 1; step();
    started = 1;
    chk("reset_abus", abus, 16'h0000);
    chk("reset_dataout", dataout, 16'h0000);
    chk("reset_flags", {12'h0, vin, cin, zin, sin}, 16'h0000);
    for (int i = 0; i < 8; i++) begin
      idle(); tp = 1; rdr = 1; pa = 3'(i); lmar = 1; step();
      chk("reset_bank", abus, 16'h0000);
    end

    load_mdr(16'h000C);
    chk("mdr_datain", dataout, 16'h000C);
    idle(); tmdr2x = 1; ldx = 1; step();
    idle(); t2 = 1; ldy = 1; step();
    idle(); fnsel = 3'b000; lt = 1; step();
    chk("add_flags", {12'h0, vin, cin, zin, sin}, 16'h0000);
    t_to_mar();
    chk("add_result", abus, 16'h000E);

    idle(); t2 = 1; ldx = 1; ldy = 1; step();
    idle(); fnsel = 3'b001; lt = 1; step();
    chk("sub_zero_flags", {12'h0, vin, cin, zin, sin}, 16'h0002);
    t_to_mar();
    chk("sub_zero_result", abus, 16'h0000);
    load_x_from(16'h0001);
    idle(); fnsel = 3'b001; lt = 1; step();
    chk("sub_borrow_flags", {12'h0, vin, cin, zin, sin}, 16'h0005);
    t_to_mar();
    chk("sub_borrow_result", abus, 16'hFFFF);

    load_x_from(16'h7FFF);
    load_mdr(16'h0001);
    idle(); lir = 1; step();
    idle(); tmdrext = 1; ldy = 1; step();
    idle(); fnsel = 3'b000; lt = 1; step();
    chk("add_ovf_flags", {12'h0, vin, cin, zin, sin}, 16'h0009);
    t_to_mar();
    chk("add_ovf_result", abus, 16'h8000);

    load_x_from(16'h0404);
    idle(); fnsel = 3'b111; lt = 1; step();
    idle(); tt = 1; wrr = 1; wpa = 3'd1; step();
    load_x_from(16'h0407);
    idle(); fnsel = 3'b111; lt = 1; step();
    idle(); tt = 1; wrr = 1; wpa = 3'd2; step();
    idle(); tp = 1; rdr = 1; pa = 3'd1; lmar = 1; step();
    chk("bank_r1", abus, 16'h0404);
    idle(); tp = 1; rdr = 1; pa = 3'd2; lmar = 1; step();
    chk("bank_r2", abus, 16'h0407);
    idle(); tp = 1; rdr = 0; pa = 3'd2; lmar = 1; step();
    chk("bank_rdr0", abus, 16'h0000);

    load_mdr(16'h0080);
    idle(); lir = 1; step();
    idle(); tmdrext = 1; lmar = 1; step();
    chk("sign_ext", abus, 16'hFF80);
    load_x_from(16'h1234);
    idle(); rmarx = 1; lmar = 1; step();
    chk("mar_from_x", abus, 16'h1234);

    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 59) == 0);
      {lmar, lt, lpc, lir, lmdr, ldx, ldy} = 7'($urandom);
      {tt, tpc, tp, t2, tmdrext} = 5'($urandom) & 5'($urandom);
      {tmdr2x, rmdri, rmarx, rdr, wrr} = 5'($urandom);
      pa = 3'($urandom); wpa = 3'($urandom); fnsel = 3'($urandom);
      datain = ($urandom_range(0, 3) == 0) ? 16'h7FFF + 16'($urandom_range(0, 2)) : 16'($urandom);
      step();
    end

    idle();
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
